// File: rtl/sampler_voice.sv
// Priority key decoder and square-wave voice: latches the lowest held key and plays its pitch, with a release tail.
// Latency: keys are registered once, so a key change reaches note_code/active/releasing two clock edges later.
// No backpressure: the voice free-runs. Optional octave shift ports appear when SAMPLER_VOICE_OCTAVE_EN is defined.
module sampler_voice #(
    parameter int NUM_KEYS       = 16,
    parameter int CNT_W          = 20,
    parameter int BASE_HALF      = 95556,
    parameter int STEP_HALF      = 4000,
    parameter int RELEASE_CYCLES = 2500000,
    parameter int CODE_W         = 5
) (
    input  logic                clock,
    input  logic                reset,
`ifdef SAMPLER_VOICE_OCTAVE_EN
    input  logic                oct_up,
    input  logic                oct_dn,
`endif
    input  logic [NUM_KEYS-1:0] keys,
    output logic [CODE_W-1:0]   note_code,
    output logic                tone_out,
    output logic                active,
    output logic                releasing
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    localparam int HW = CNT_W + 8;

    // Half-period for key k with the octave applied; never below 2, never above the counter range.
    function automatic logic [CNT_W-1:0] calc_half(input logic [CODE_W-1:0] k, input logic [1:0] oct);
        logic [HW-1:0] raw;
        logic [HW-1:0] v;
        raw = HW'(BASE_HALF) - HW'(k) * HW'(STEP_HALF);
        if (raw[HW-1] || raw < HW'(2)) raw = HW'(2);
        if (oct == 2'b01)      v = raw >> 1;
        else if (oct == 2'b11) v = raw << 1;
        else                   v = raw;
        if (v < HW'(2)) v = HW'(2);
        if (v > HW'((64'd1 << CNT_W) - 64'd1)) v = HW'((64'd1 << CNT_W) - 64'd1);
        return v[CNT_W-1:0];
    endfunction

    logic [NUM_KEYS-1:0] key_q;
    logic [1:0]          state_q, state_d;
    logic [CODE_W-1:0]   idx_q, idx_d;
    logic [CODE_W-1:0]   note_q, note_d;
    logic [CNT_W-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]    half_q, half_d;
    logic [CNT_W-1:0]    rel_q, rel_d;
    logic                tone_q, tone_d;
    logic                active_q, releasing_q;
    logic [CODE_W-1:0]   sel;
    logic                any;
    logic                wrap;
    logic [1:0]          oct_cur;

`ifdef SAMPLER_VOICE_OCTAVE_EN
    logic       up_prev_q, dn_prev_q;
    logic [1:0] oct_q;

    // Rising-edge detect on the octave buttons; octave saturates at -1..+1 and both at once cancel.
    always_ff @(posedge clock) begin
        if (reset) begin
            up_prev_q <= 1'b0;
            dn_prev_q <= 1'b0;
            oct_q     <= 2'b00;
        end else begin
            up_prev_q <= oct_up;
            dn_prev_q <= oct_dn;
            if (oct_up && !up_prev_q && !(oct_dn && !dn_prev_q) && oct_q != 2'b01)
                oct_q <= oct_q + 2'b01;
            else if (oct_dn && !dn_prev_q && !(oct_up && !up_prev_q) && oct_q != 2'b11)
                oct_q <= oct_q - 2'b01;
        end
    end
    assign oct_cur = oct_q;
`else
    assign oct_cur = 2'b00;
`endif

    // Fixed priority: lowest set index wins.
    always_comb begin
        sel = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (key_q[k]) sel = CODE_W'(k);
        end
    end

    assign any  = |key_q;
    assign wrap = (phase_q == half_q - CNT_W'(1));

    // Voice FSM plus tone generator; the registered half-period only changes at latch or phase wrap.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        note_d  = note_q;
        phase_d = phase_q;
        half_d  = half_q;
        rel_d   = rel_q;
        tone_d  = tone_q;
        case (state_q)
            S_PLAY: begin
                if (!any) begin
                    if (RELEASE_CYCLES == 0) begin
                        state_d = S_IDLE;
                        note_d  = '0;
                        tone_d  = 1'b0;
                        phase_d = '0;
                    end else begin
                        state_d = S_REL;
                        rel_d   = CNT_W'(RELEASE_CYCLES - 1);
                    end
                end else if (sel != idx_q) begin
                    state_d = S_PLAY;
                end
            end
            S_REL: begin
                if (any) begin
                    state_d = S_PLAY;
                end else if (rel_q == '0) begin
                    state_d = S_IDLE;
                    note_d  = '0;
                    tone_d  = 1'b0;
                    phase_d = '0;
                end else begin
                    rel_d = rel_q - CNT_W'(1);
                end
            end
            default: begin
                tone_d = 1'b0;
                if (any) state_d = S_PLAY;
            end
        endcase

        // Latch: entering PLAY from IDLE/RELEASE, or a different key winning priority in PLAY.
        if (any && (state_q != S_PLAY || sel != idx_q)) begin
            idx_d   = sel;
            note_d  = sel + CODE_W'(1);
            phase_d = '0;
            tone_d  = 1'b0;
            half_d  = calc_half(sel, oct_cur);
        end else if (state_d != S_IDLE) begin
            if (wrap) begin
                tone_d  = ~tone_q;
                phase_d = '0;
                half_d  = calc_half(idx_q, oct_cur);
            end else begin
                phase_d = phase_q + CNT_W'(1);
            end
        end
    end

    // State registers; status flags decode the next state so they move with note_code.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_q       <= '0;
            state_q     <= S_IDLE;
            idx_q       <= '0;
            note_q      <= '0;
            phase_q     <= '0;
            half_q      <= '0;
            rel_q       <= '0;
            tone_q      <= 1'b0;
            active_q    <= 1'b0;
            releasing_q <= 1'b0;
        end else begin
            key_q       <= keys;
            state_q     <= state_d;
            idx_q       <= idx_d;
            note_q      <= note_d;
            phase_q     <= phase_d;
            half_q      <= half_d;
            rel_q       <= rel_d;
            tone_q      <= tone_d;
            active_q    <= (state_d != S_IDLE);
            releasing_q <= (state_d == S_REL);
        end
    end

    assign note_code = note_q;
    assign tone_out  = tone_q;
    assign active    = active_q;
    assign releasing = releasing_q;

endmodule

// File: tb/tb_sampler_voice.sv
// Bench for sampler_voice with small parameters: directed table, hand-written timing sequences, random run.
// Every clock edge is also compared against a behavioural model (tone derived from time since latch).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_sampler_voice;

    localparam int NK  = 4;
    localparam int REL = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] keys;
    logic [2:0] note_code;
    logic       tone_out;
    logic       active;
    logic       releasing;

    int checks   = 0;
    int failures = 0;

    // Model state
    int         m_state = 0;   // 0 idle, 1 play, 2 release
    int         m_note  = 0;
    int         m_t     = 0;   // clocks since latch
    int         m_rem   = 0;
    logic [3:0] m_key   = 4'b0;

    sampler_voice #(
        .NUM_KEYS(NK), .CNT_W(8), .BASE_HALF(20), .STEP_HALF(4),
        .RELEASE_CYCLES(REL), .CODE_W(3)
    ) dut (
        .clock(clk), .reset(rst), .keys(keys),
        .note_code(note_code), .tone_out(tone_out),
        .active(active), .releasing(releasing)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input logic [3:0] k);
        for (int i = 0; i < NK; i++) if (k[i]) return i;
        return -1;
    endfunction

    function automatic int half_of(input int note);
        return 20 - 4 * (note - 1);
    endfunction

    function automatic int exp_tone();
        if (m_state == 0) return 0;
        return (m_t / half_of(m_note)) % 2;
    endfunction

    task automatic latch(input int s);
        m_state = 1;
        m_note  = s + 1;
        m_t     = 0;
    endtask

    task automatic model_edge(input logic r, input logic [3:0] k);
        int s;
        if (r) begin
            m_state = 0; m_note = 0; m_t = 0; m_rem = 0; m_key = 4'b0;
            return;
        end
        s = lowest(m_key);
        case (m_state)
            0: if (s >= 0) latch(s);
            1: begin
                if (s < 0) begin m_state = 2; m_rem = REL - 1; m_t++; end
                else if (s + 1 != m_note) latch(s);
                else m_t++;
            end
            default: begin
                if (s >= 0) latch(s);
                else if (m_rem == 0) begin m_state = 0; m_note = 0; m_t = 0; end
                else begin m_rem--; m_t++; end
            end
        endcase
        m_key = k;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string nm);
        checks++;
        if (int'(note_code) != m_note || int'(tone_out) != exp_tone() ||
            active != (m_state != 0) || releasing != (m_state == 2)) begin
            failures++;
            $display("FAIL %s: got note=%0d tone=%0d act=%0d rel=%0d expected note=%0d tone=%0d act=%0d rel=%0d (t=%0t)",
                     nm, note_code, tone_out, active, releasing,
                     m_note, exp_tone(), m_state != 0, m_state == 2, $time);
        end
    endtask

    // One clock: drive, take the edge, advance the model, sample 1 unit later.
    task automatic tick(input logic r, input logic [3:0] k);
        rst  = r;
        keys = k;
        @(posedge clk);
        model_edge(r, k);
        #1;
        chk_model("model");
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] keys;
        int         hold;
        int         note;
        int         act;
        int         rel;
    } vec_t;

    vec_t vecs[11];
    int   tone_at[40];

    initial begin
        rst  = 1'b1;
        keys = 4'b0;
        #1;

        vecs[0]  = '{1'b1, 4'b0000,  2, 0, 0, 0};
        vecs[1]  = '{1'b0, 4'b0000, 50, 0, 0, 0};
        vecs[2]  = '{1'b0, 4'b0110,  5, 2, 1, 0};
        vecs[3]  = '{1'b0, 4'b0100,  3, 3, 1, 0};
        vecs[4]  = '{1'b0, 4'b1000,  3, 4, 1, 0};
        vecs[5]  = '{1'b0, 4'b0000,  2, 4, 1, 1};
        vecs[6]  = '{1'b0, 4'b0000, 10, 0, 0, 0};
        vecs[7]  = '{1'b0, 4'b1111,  3, 1, 1, 0};
        vecs[8]  = '{1'b1, 4'b1111,  1, 0, 0, 0};
        vecs[9]  = '{1'b0, 4'b1111,  1, 0, 0, 0};
        vecs[10] = '{1'b0, 4'b1111,  1, 1, 1, 0};

        for (int v = 0; v < 11; v++) begin
            for (int c = 0; c < vecs[v].hold; c++) tick(vecs[v].rst, vecs[v].keys);
            chk($sformatf("vec%0d_note", v), note_code, vecs[v].note);
            chk($sformatf("vec%0d_active", v), active, vecs[v].act);
            chk($sformatf("vec%0d_releasing", v), releasing, vecs[v].rel);
        end

        // Key 2 from idle: note at second edge, first rise 12 clocks later, period 24.
        tick(1'b1, 4'b0000);
        tick(1'b0, 4'b0000);
        tick(1'b0, 4'b0100);
        tick(1'b0, 4'b0100);
        chk("k2_note", note_code, 3);
        chk("k2_active", active, 1);
        chk("k2_tone_at_latch", tone_out, 0);
        for (int i = 1; i <= 37; i++) begin
            tick(1'b0, 4'b0100);
            tone_at[i] = int'(tone_out);
        end
        chk("k2_tone_11", tone_at[11], 0);
        chk("k2_tone_12", tone_at[12], 1);
        chk("k2_tone_23", tone_at[23], 1);
        chk("k2_tone_24", tone_at[24], 0);
        chk("k2_tone_36", tone_at[36], 1);

        // Keys 1+2: key 1 wins (half 16); switching to key 2 alone forces tone low on re-latch.
        tick(1'b0, 4'b0110);
        tick(1'b0, 4'b0110);
        chk("relatch_note2", note_code, 2);
        for (int i = 0; i < 18; i++) tick(1'b0, 4'b0110);
        chk("relatch_tone_high", tone_out, 1);
        tick(1'b0, 4'b0100);
        tick(1'b0, 4'b0100);
        chk("relatch_note3", note_code, 3);
        chk("relatch_tone_low", tone_out, 0);

        // Key 0 release tail, then re-press during release.
        for (int i = 0; i < 30; i++) tick(1'b0, 4'b0001);
        tick(1'b0, 4'b0000);
        chk("rel_not_yet", releasing, 0);
        tick(1'b0, 4'b0000);
        chk("rel_flag", releasing, 1);
        chk("rel_note_held", note_code, 1);
        for (int i = 0; i < 9; i++) tick(1'b0, 4'b0000);
        chk("rel_last_note", note_code, 1);
        tick(1'b0, 4'b0000);
        chk("rel_idle_note", note_code, 0);
        chk("rel_idle_active", active, 0);
        for (int i = 0; i < 10; i++) tick(1'b0, 4'b0001);
        for (int i = 0; i < 5; i++) tick(1'b0, 4'b0000);
        chk("repress_in_rel", releasing, 1);
        tick(1'b0, 4'b0001);
        tick(1'b0, 4'b0001);
        chk("repress_note", note_code, 1);
        chk("repress_releasing", releasing, 0);
        chk("repress_tone", tone_out, 0);

        // Reset mid-play with key 3 held.
        for (int i = 0; i < 10; i++) tick(1'b0, 4'b1000);
        chk("pre_rst_note", note_code, 4);
        tick(1'b1, 4'b1000);
        chk("rst_note", note_code, 0);
        chk("rst_active", active, 0);
        tick(1'b0, 4'b1000);
        chk("rst_plus1_note", note_code, 0);
        tick(1'b0, 4'b1000);
        chk("rst_plus2_note", note_code, 4);

        // Random segments against the model.
        for (int seg = 0; seg < 300; seg++) begin
            logic [3:0] k;
            logic       r;
            int         hold;
            k    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) k = 4'b0;
            r    = ($urandom_range(0, 49) == 0);
            hold = r ? 1 : $urandom_range(1, 40);
            for (int c = 0; c < hold; c++) tick(r, k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
